fir_mac_seq: RTL



---
 rtl/fir_mac_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fir_mac_seq.sv
// fir_mac_seq -- time-multiplexed FIR filter with one shared multiply-accumulator.
//
// Each output needs TAPS MAC cycles. Frames have a fixed length of FRAME_LEN
// samples. At the end of each frame the block shifts zeros into the delay line,
// so every frame produces exactly FRAME_LEN outputs.
//
// Optional feature: define FIR_SAT_EN to clamp the rounded result to DW bits and
// report clipping on out_sat. When FIR_SAT_EN is undefined, the result wraps and
// out_sat is tied to 0.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   in_valid/in_ready      input sample handshake; in_data is the signed DW-bit sample
//   out_valid/out_ready    output sample handshake; out_data is the signed DW-bit result
//   out_sat                out_data was clipped (FIR_SAT_EN builds only)
//   frame_done             one-cycle pulse after the last output of a frame is accepted
//   busy                   FSM is in any state other than IDLE
//   coef_we/addr/data      coefficient write port; writes take effect only while in IDLE
module fir_mac_seq #(
  parameter int TAPS      = 32,
  parameter int DW        = 16,
  parameter int CW        = 20,
  parameter int CFRAC     = 16,
  parameter int FRAME_LEN = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DW-1:0]             in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW-1:0]             out_data,
  output logic                      out_sat,
  output logic                      frame_done,
  output logic                      busy,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [CW-1:0]             coef_data
);

  localparam int KW  = $clog2(TAPS);
  localparam int PW  = DW + CW;
  localparam int AW  = PW + KW;
  localparam int ICW = $clog2(FRAME_LEN + 1);
  localparam int SCW = $clog2(FRAME_LEN + TAPS);

  localparam logic [ICW-1:0]       IN_LAST  = ICW'(FRAME_LEN);
  localparam logic [SCW-1:0]       SH_LAST  = SCW'(FRAME_LEN + TAPS - 1);
  localparam logic [SCW-1:0]       SH_FIRST = SCW'(TAPS);
  localparam logic [KW-1:0]        K_LAST   = KW'(TAPS - 1);
  localparam logic signed [AW:0]   HALF     = (AW+1)'(1) << (CFRAC - 1);
  localparam logic signed [DW-1:0] DMAX     = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] DMIN     = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_MAC, S_OUT, S_DONE} state_t;

  state_t                state, state_nx;
  logic signed [DW-1:0]  dly  [TAPS];
  logic signed [CW-1:0]  coef [TAPS];
  logic [ICW-1:0]        in_cnt;
  logic [SCW-1:0]        sh_cnt, sh_next;
  logic [KW-1:0]         k;
  logic signed [AW-1:0]  acc, sum;
  logic signed [PW-1:0]  prod;
  logic signed [DW-1:0]  res, out_q;
  logic                  res_sat, sat_q;
  logic                  accept;

  assign in_ready   = (state == S_IDLE) && (in_cnt < IN_LAST) && !rst;
  assign accept     = in_ready && in_valid;
  assign busy       = (state != S_IDLE);
  assign out_valid  = (state == S_OUT);
  assign frame_done = (state == S_DONE);
  assign out_data   = out_q;
  assign out_sat    = sat_q && out_valid;
  assign sh_next    = sh_cnt + 1'b1;

  assign prod = PW'(coef[k]) * PW'(dly[k]);
  assign sum  = acc + AW'(prod);

  // The result is rounded from acc plus the last product, so out_data is ready
  // when the FSM enters OUT.
`ifdef FIR_SAT_EN
  logic signed [AW:0] rnd;
  always_comb begin
    rnd     = ((AW+1)'(sum) + HALF) >>> CFRAC;
    res     = rnd[DW-1:0];
    res_sat = 1'b0;
    if (rnd > (AW+1)'(DMAX)) begin
      res     = DMAX;
      res_sat = 1'b1;
    end else if (rnd < (AW+1)'(DMIN)) begin
      res     = DMIN;
      res_sat = 1'b1;
    end
  end
`else
  always_comb begin
    res     = DW'(((AW+1)'(sum) + HALF) >>> CFRAC);
    res_sat = 1'b0;
  end
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (in_cnt == IN_LAST)                   state_nx = S_FLUSH;
        else if (accept && (sh_next >= SH_FIRST)) state_nx = S_MAC;
      end
      // FLUSH stays put when a frame is shorter than the warm-up.
      S_FLUSH: if (sh_next >= SH_FIRST) state_nx = S_MAC;
      S_MAC:   if (k == K_LAST) state_nx = S_OUT;
      S_OUT: begin
        if (out_ready) begin
          if (sh_cnt == SH_LAST)     state_nx = S_DONE;
          else if (in_cnt < IN_LAST) state_nx = S_IDLE;
          else                       state_nx = S_FLUSH;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      in_cnt <= '0;
      sh_cnt <= '0;
      k      <= '0;
      acc    <= '0;
      out_q  <= '0;
      sat_q  <= 1'b0;
      for (int unsigned i = 0; i < TAPS; i++) dly[i] <= '0;
    end else begin
      state <= state_nx;
      if (accept || (state == S_FLUSH)) begin
        for (int unsigned i = TAPS - 1; i > 0; i--) dly[i] <= dly[i-1];
        dly[0] <= accept ? $signed(in_data) : '0;
        sh_cnt <= sh_next;
      end
      if (accept) in_cnt <= in_cnt + 1'b1;
      if (state == S_DONE) begin
        in_cnt <= '0;
        sh_cnt <= '0;
      end
      if (state == S_MAC) begin
        acc <= sum;
        k   <= (k == K_LAST) ? '0 : k + 1'b1;
        if (k == K_LAST) begin
          out_q <= res;
          sat_q <= res_sat;
        end
      end else begin
        acc <= '0;
        k   <= '0;
      end
    end
  end

  // Coefficients survive reset and frame boundaries.
  always_ff @(posedge clk) begin
    if (coef_we && (state == S_IDLE)) coef[coef_addr] <= $signed(coef_data);
  end

endmodule
